// File: rtl/button_event_gen_pkg.sv
// -----------------------------------------------------------------------------
// btn_evt_pkg
// Shared definitions for the button event generator:
//   - btn_state_e : FSM state encoding (IDLE / PRESSED / REPEAT)
//   - DEF_*       : default timing constants for a 50 MHz clock
// -----------------------------------------------------------------------------
package btn_evt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      REPEAT  = 2'd2
   } btn_state_e;

   // 1 s long-press and 200 ms auto-repeat at 50 MHz
   localparam int DEF_LONG_CYCLES   = 50_000_000;
   localparam int DEF_REPEAT_CYCLES = 10_000_000;
   localparam int DEF_CNT_BITS      = 26;
   localparam int DEF_RPT_BITS      = 8;

endpackage

// File: rtl/button_event_gen_if.sv
// -----------------------------------------------------------------------------
// button_event_gen_if
// Connects a debounced button level to the event generator and carries the
// resulting event pulses back to the control logic.
//   btn_clean     : debounced level, 1 = pressed
//   press_pulse   : one-cycle pulse on press
//   release_pulse : one-cycle pulse on release
//   long_pulse    : one-cycle pulse when the hold reaches the long threshold
//   repeat_pulse  : one-cycle pulse per auto-repeat interval
//   held          : level, high while a press is in progress
//   repeat_count  : saturating count of repeats in the current/last hold
// Modports:
//   master : the side that supplies btn_clean and consumes events
//   slave  : the event generator itself
// -----------------------------------------------------------------------------
interface button_event_gen_if
   import btn_evt_pkg::*;
#(
   parameter int RPT_BITS = DEF_RPT_BITS
);

   logic                btn_clean;
   logic                press_pulse;
   logic                release_pulse;
   logic                long_pulse;
   logic                repeat_pulse;
   logic                held;
   logic [RPT_BITS-1:0] repeat_count;

   modport master (
      output btn_clean,
      input  press_pulse, release_pulse, long_pulse, repeat_pulse,
      input  held, repeat_count
   );

   modport slave (
      input  btn_clean,
      output press_pulse, release_pulse, long_pulse, repeat_pulse,
      output held, repeat_count
   );

endinterface

// File: rtl/button_event_gen_hold_timer.sv
// -----------------------------------------------------------------------------
// hold_timer
// Free-running hold counter with synchronous clear and enable. When enabled
// and the count equals term, done is high for that cycle and the counter
// restarts from zero on the same edge, so done never lasts more than one
// cycle and the counter never wraps.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear (wins over everything else)
//   en       : count enable; the counter holds its value when low
//   term     : terminal count (threshold - 1)
//   done     : combinational, high on the cycle the count reaches term
// -----------------------------------------------------------------------------
module hold_timer #(
   parameter int CNT_BITS = 26
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                en,
   input  logic [CNT_BITS-1:0] term,
   output logic                done
);

   logic [CNT_BITS-1:0] cnt;

   assign done = en & ~clr & (cnt == term);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || done)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/button_event_gen.sv
// -----------------------------------------------------------------------------
// button_event_gen
// Turns a debounced button level into one-cycle user events: press, release,
// long-press and (optionally) auto-repeat. All outputs are registered; an
// event detected on edge N is visible for exactly one cycle after edge N.
//
// Build option:
//   BUTTON_AUTO_REPEAT_EN  defined   -> repeat_pulse every REPEAT_CYCLES while
//                                       held past the long-press point, and
//                                       repeat_count counts them (saturating).
//                          undefined -> after long_pulse the FSM only waits for
//                                       release; repeat_pulse = 0 and
//                                       repeat_count = 0.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : button_event_gen_if.slave (btn_clean in, event outputs)
// Parameters:
//   LONG_CYCLES   : hold length before long_pulse
//   REPEAT_CYCLES : interval between repeat pulses
//   CNT_BITS      : hold counter width, 2^CNT_BITS > max(LONG, REPEAT)
//   RPT_BITS      : repeat_count width
// -----------------------------------------------------------------------------
module button_event_gen
   import btn_evt_pkg::*;
#(
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
   parameter int CNT_BITS      = DEF_CNT_BITS,
   parameter int RPT_BITS      = DEF_RPT_BITS
) (
   input  logic               clk,
   input  logic               rst,
   button_event_gen_if.slave  bus
);

   localparam logic [CNT_BITS-1:0] LONG_TERM   = CNT_BITS'(LONG_CYCLES - 1);
   localparam logic [CNT_BITS-1:0] REPEAT_TERM = CNT_BITS'(REPEAT_CYCLES - 1);

`ifdef BUTTON_AUTO_REPEAT_EN
   localparam bit                  AUTO_RPT = 1'b1;
   localparam logic [RPT_BITS-1:0] RPT_MAX  = '1;
`else
   localparam bit                  AUTO_RPT = 1'b0;
`endif

   btn_state_e          state;
   logic                btn_q;
   logic                armed;
   logic                rise, fall;
   logic                tmr_clr, tmr_en, tmr_done;
   logic [CNT_BITS-1:0] tmr_term;

   logic                press_q, rel_q, long_q, held_q;
   logic [RPT_BITS-1:0] rpt_cnt;

   // armed is low until the first edge after reset, so a button that is
   // still down when reset is released is not mistaken for a fresh press:
   // btn_q picks up the level on that edge and only a later 0->1 counts.
   assign rise = armed & bus.btn_clean & ~btn_q;
   assign fall = armed & ~bus.btn_clean & btn_q;

   // Counter runs in PRESSED and, with auto-repeat, in REPEAT; otherwise it
   // is frozen (it was just cleared by the long-press threshold).
   assign tmr_clr  = (state == IDLE) & rise;
   assign tmr_en   = (state == PRESSED) | (AUTO_RPT & (state == REPEAT));
   assign tmr_term = (state == PRESSED) ? LONG_TERM : REPEAT_TERM;

   hold_timer #(
      .CNT_BITS (CNT_BITS)
   ) u_hold_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (tmr_clr),
      .en   (tmr_en),
      .term (tmr_term),
      .done (tmr_done)
   );

`ifdef BUTTON_AUTO_REPEAT_EN
   logic rpt_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         btn_q   <= 1'b0;
         armed   <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
         held_q  <= 1'b0;
         rpt_cnt <= '0;
`ifdef BUTTON_AUTO_REPEAT_EN
         rpt_q   <= 1'b0;
`endif
      end else begin
         btn_q   <= bus.btn_clean;
         armed   <= 1'b1;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
         rpt_q   <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (rise) begin
                  state   <= PRESSED;
                  held_q  <= 1'b1;
                  press_q <= 1'b1;
                  rpt_cnt <= '0;
               end
            end
            // Fall is tested before the threshold so a release on the
            // terminal cycle yields only release_pulse.
            PRESSED: begin
               if (fall) begin
                  state  <= IDLE;
                  held_q <= 1'b0;
                  rel_q  <= 1'b1;
               end else if (tmr_done) begin
                  state  <= REPEAT;
                  long_q <= 1'b1;
               end
            end
            REPEAT: begin
               if (fall) begin
                  state  <= IDLE;
                  held_q <= 1'b0;
                  rel_q  <= 1'b1;
               end
`ifdef BUTTON_AUTO_REPEAT_EN
               else if (tmr_done) begin
                  rpt_q <= 1'b1;
                  if (rpt_cnt != RPT_MAX)
                     rpt_cnt <= rpt_cnt + 1'b1;
               end
`endif
            end
            default: begin
               state  <= IDLE;
               held_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = rel_q;
   assign bus.long_pulse    = long_q;
   assign bus.held          = held_q;
   assign bus.repeat_count  = rpt_cnt;
`ifdef BUTTON_AUTO_REPEAT_EN
   assign bus.repeat_pulse  = rpt_q;
`else
   assign bus.repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_gen.sv
// -----------------------------------------------------------------------------
// tb_button_event_gen
// Drives btn_clean one cycle at a time and compares every registered output
// against a reference model that works from hold duration arithmetic: an
// event's type follows from how many edges have passed since the press.
// -----------------------------------------------------------------------------
module tb_button_event_gen;

   localparam int LONG = 10;
   localparam int REP  = 4;
   localparam int CB   = 4;
   localparam int RB   = 2;
   localparam int RMAX = (1 << RB) - 1;
`ifdef BUTTON_AUTO_REPEAT_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_event_gen_if #(.RPT_BITS(RB)) bus ();

   button_event_gen #(
      .LONG_CYCLES   (LONG),
      .REPEAT_CYCLES (REP),
      .CNT_BITS      (CB),
      .RPT_BITS      (RB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // {press, release, long, repeat, held, repeat_count}
   logic [6:0] obs;
   assign obs = {bus.press_pulse, bus.release_pulse, bus.long_pulse,
                 bus.repeat_pulse, bus.held, bus.repeat_count};

   int n_chk  = 0;
   int n_fail = 0;

   // ---------------- reference model ----------------
   int t;            // edge index
   bit prev, prev_ok, in_hold;
   int start, rc;
   bit e_press, e_rel, e_long, e_rpt;

   function automatic logic [6:0] exp_vec();
      return {e_press, e_rel, e_long, e_rpt, in_hold, 2'(rc)};
   endfunction

   task automatic model_reset();
      prev = 0; prev_ok = 0; in_hold = 0; rc = 0;
      e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
   endtask

   task automatic model_edge(input bit b);
      int d;
      e_press = 0; e_rel = 0; e_long = 0; e_rpt = 0;
      if (prev_ok) begin
         if (!in_hold) begin
            if (b && !prev) begin
               in_hold = 1; start = t; e_press = 1; rc = 0;
            end
         end else if (!b) begin
            in_hold = 0; e_rel = 1;
         end else begin
            d = t - start;
            if (d == LONG)
               e_long = 1;
            else if (AUTO && d > LONG && ((d - LONG) % REP) == 0)
               e_rpt = 1;
            if (AUTO && d >= LONG)
               rc = ((d - LONG) / REP > RMAX) ? RMAX : (d - LONG) / REP;
         end
      end
      prev = b; prev_ok = 1; t++;
   endtask

   task automatic step(input bit b);
      @(negedge clk);
      bus.btn_clean = b;
      @(posedge clk);
      model_edge(b);
      #1;
   endtask

   bit pat[$];
   task automatic add(input bit v, input int n);
      repeat (n) pat.push_back(v);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      bus.btn_clean = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if (obs !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state got=%b exp=%b", obs, 7'b0);
      end
      #1 rst = 1'b0;
      model_reset();
   endtask

   task automatic test_tap();
      int held_cnt = 0;
      pat.delete(); add(0, 2); add(1, 3); add(0, 3);
      foreach (pat[i]) begin
         step(pat[i]);
         held_cnt += bus.held;
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL tap idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      n_chk++;
      if (held_cnt !== 3) begin
         n_fail++;
         $display("FAIL tap_held_cycles got=%0d exp=3", held_cnt);
      end
   endtask

   task automatic test_long_hold();
      int p_idx = -1, l_idx = -1, n_rpt = 0;
      pat.delete(); add(0, 2); add(1, 30); add(0, 3);
      foreach (pat[i]) begin
         step(pat[i]);
         if (bus.press_pulse) p_idx = i;
         if (bus.long_pulse)  l_idx = i;
         n_rpt += bus.repeat_pulse;
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL long_hold idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      n_chk++;
      if (l_idx - p_idx !== LONG) begin
         n_fail++;
         $display("FAIL long_latency got=%0d exp=%0d", l_idx - p_idx, LONG);
      end
      n_chk++;
      if (n_rpt !== (AUTO ? 4 : 0)) begin
         n_fail++;
         $display("FAIL repeat_pulses got=%0d exp=%0d", n_rpt, AUTO ? 4 : 0);
      end
      n_chk++;
      if (bus.repeat_count !== (AUTO ? 2'd3 : 2'd0)) begin
         n_fail++;
         $display("FAIL repeat_sat got=%0d exp=%0d", bus.repeat_count, AUTO ? 3 : 0);
      end
   endtask

   task automatic test_fall_on_threshold();
      int n_long = 0, n_rel = 0;
      pat.delete(); add(0, 2); add(1, 10); add(0, 3);
      foreach (pat[i]) begin
         step(pat[i]);
         n_long += bus.long_pulse;
         n_rel  += bus.release_pulse;
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL fall_thresh idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      n_chk++;
      if (n_long !== 0 || n_rel !== 1) begin
         n_fail++;
         $display("FAIL fall_thresh_counts long=%0d rel=%0d exp long=0 rel=1", n_long, n_rel);
      end
   endtask

   task automatic test_back_to_back();
      int r_idx = -1, p_idx = -1;
      pat.delete(); add(0, 2); add(1, 16); add(0, 1); add(1, 5); add(0, 2);
      foreach (pat[i]) begin
         step(pat[i]);
         if (bus.release_pulse && r_idx < 0) r_idx = i;
         if (bus.press_pulse) p_idx = i;
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL back_to_back idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      n_chk++;
      if (p_idx - r_idx !== 1) begin
         n_fail++;
         $display("FAIL b2b_gap got=%0d exp=1", p_idx - r_idx);
      end
   endtask

   task automatic test_reset_mid_hold();
      int n_press = 0;
      pat.delete(); add(0, 2); add(1, 20);
      foreach (pat[i]) begin
         step(pat[i]);
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL pre_reset idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      // asynchronous reset between edges with the button still down
      #1 rst = 1'b1;
      #1;
      n_chk++;
      if (obs !== 7'b0) begin
         n_fail++;
         $display("FAIL async_reset got=%b exp=%b", obs, 7'b0);
      end
      #1 rst = 1'b0;
      model_reset();
      pat.delete(); add(1, 5); add(0, 2); add(1, 3); add(0, 2);
      foreach (pat[i]) begin
         step(pat[i]);
         n_press += bus.press_pulse;
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL post_reset idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
      n_chk++;
      if (n_press !== 1) begin
         n_fail++;
         $display("FAIL post_reset_presses got=%0d exp=1", n_press);
      end
   endtask

   task automatic test_random();
      bit lvl = 1'b0;
      pat.delete();
      repeat (24) begin
         add(lvl, $urandom_range(1, 20));
         lvl = ~lvl;
      end
      add(0, 2);
      foreach (pat[i]) begin
         step(pat[i]);
         n_chk++;
         if (obs !== exp_vec()) begin
            n_fail++;
            $display("FAIL random idx=%0d got=%b exp=%b", i, obs, exp_vec());
         end
      end
   endtask

   initial begin
      t = 0;
      model_reset();
      test_reset();
      test_tap();
      test_long_hold();
      test_fall_on_threshold();
      test_back_to_back();
      test_reset_mid_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

endmodule
